// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: default bus width and a reusable binary-to-Gray helper.
package gray_pkg;

   localparam int unsigned GRAY_WIDTH_DEFAULT = 8;
   localparam int unsigned GRAY_MAX_WIDTH     = 64;

   // Reflected-binary encode; narrower buses zero-extend in and truncate out.
   function automatic logic [GRAY_MAX_WIDTH-1:0] to_gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/bin2gray_strobed_if.sv
// Strobed binary-in / Gray-out bus between a producer (master) and the encoder (slave).
interface bin2gray_strobed_if
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) ();

   logic [WIDTH-1:0] a;
   logic             strobe;
   logic [WIDTH-1:0] b;
   logic             b_valid;

   modport master (output a, output strobe, input b, input b_valid);
   modport slave  (input a, input strobe, output b, output b_valid);

endinterface

// File: rtl/gray_encode_comb.sv
// Purely combinational WIDTH-bit binary-to-Gray encoder.
module gray_encode_comb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray_c
);

   assign gray_c[WIDTH-1] = bin[WIDTH-1];

   // Each lower Gray bit flags a change between adjacent binary bits.
   for (genvar i = 0; i < int'(WIDTH) - 1; i++) begin : g_bit
      assign gray_c[i] = bin[i+1] ^ bin[i];
   end

endmodule

// File: rtl/bin2gray_strobed.sv
// Strobe-qualified binary-to-Gray encoder; b captures g(a) on strobe, b_valid pulses the update.
module bin2gray_strobed
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   bin2gray_strobed_if.slave bus
);

   logic [WIDTH-1:0] gray_c;
   logic [WIDTH-1:0] b_q;
   logic             b_valid_q;

   gray_encode_comb #(
      .WIDTH (WIDTH)
   ) u_encode (
      .bin    (bus.a),
      .gray_c (gray_c)
   );

   // Capture register; b holds between strobes, b_valid marks the update cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q       <= '0;
         b_valid_q <= 1'b0;
      end else begin
         b_valid_q <= bus.strobe;
         if (bus.strobe) begin
            b_q <= gray_c;
         end
      end
   end

   assign bus.b       = b_q;
   assign bus.b_valid = b_valid_q;

endmodule

// File: tb/tb_bin2gray_strobed.sv
// Directed and randomized checks of bin2gray_strobed against hand-computed values and a reference register.
module tb_bin2gray_strobed;
   import gray_pkg::*;

   localparam int unsigned W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [W-1:0] model_b;
   logic         model_v;

   bin2gray_strobed_if #(.WIDTH(W)) bus ();

   bin2gray_strobed #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: inputs were driven at a falling edge, outputs sampled at the next falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic strobe_check(input logic [W-1:0] a_v, input logic [W-1:0] exp_b, input string tag);
      bus.a      = a_v;
      bus.strobe = 1'b1;
      cyc();
      bus.strobe = 1'b0;
      check({tag, "_b"}, bus.b, exp_b);
      check({tag, "_v"}, 8'(bus.b_valid), 8'h01);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b1;
      bus.a      = 8'hFF;
      bus.strobe = 1'b1;

      // Asynchronous reset takes effect without a clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_b", bus.b, 8'h00);
      check("rst_v", 8'(bus.b_valid), 8'h00);
      @(negedge clk);
      check("rst_hold_b", bus.b, 8'h00);
      check("rst_hold_v", 8'(bus.b_valid), 8'h00);
      rst_n = 1'b1;
      strobe_check(8'hFF, 8'h80, "rel");

      // Directed encodings.
      strobe_check(8'h00, 8'h00, "enc00");
      strobe_check(8'h01, 8'h01, "enc01");
      strobe_check(8'h02, 8'h03, "enc02");
      strobe_check(8'h5A, 8'h77, "enc5A");
      strobe_check(8'h7F, 8'h40, "enc7F");
      strobe_check(8'h80, 8'hC0, "enc80");
      strobe_check(8'hFF, 8'h80, "encFF");
      strobe_check(8'hFF, 8'h80, "encFF_again");

      // Hold while strobe is low and a changes.
      strobe_check(8'h5A, 8'h77, "hold_set");
      bus.a = 8'h00;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("hold_b", bus.b, 8'h77);
         check("hold_v", 8'(bus.b_valid), 8'h00);
      end

      // Back-to-back strobes.
      bus.strobe = 1'b1;
      bus.a = 8'h03; cyc();
      check("b2b0_b", bus.b, 8'h02); check("b2b0_v", 8'(bus.b_valid), 8'h01);
      bus.a = 8'h04; cyc();
      check("b2b1_b", bus.b, 8'h06); check("b2b1_v", 8'(bus.b_valid), 8'h01);
      bus.a = 8'h05; cyc();
      check("b2b2_b", bus.b, 8'h07); check("b2b2_v", 8'(bus.b_valid), 8'h01);
      bus.strobe = 1'b0;
      cyc();
      check("b2b_end_b", bus.b, 8'h07); check("b2b_end_v", 8'(bus.b_valid), 8'h00);

      // Mid-operation reset between clock edges.
      strobe_check(8'h80, 8'hC0, "mid_set");
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_b", bus.b, 8'h00);
      check("mid_rst_v", 8'(bus.b_valid), 8'h00);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mid_after_b", bus.b, 8'h00);
      strobe_check(8'h80, 8'hC0, "mid_restore");

      // Random regression against a reference register.
      model_b = 8'hC0;
      model_v = 1'b0;
      for (int it = 0; it < 20000; it++) begin
         int idle;
         for (int k = 0; k < int'(W); k++) begin
            bus.a[k] = ($urandom_range(0, 99) < 40);
         end
         bus.strobe = 1'b1;
         model_b = 8'(to_gray(64'(bus.a)));
         model_v = 1'b1;
         cyc();
         check("rnd_b", bus.b, model_b);
         check("rnd_v", 8'(bus.b_valid), 8'(model_v));
         bus.strobe = 1'b0;
         model_v = 1'b0;
         idle = int'($urandom_range(1, 2));
         for (int j = 0; j < idle; j++) begin
            bus.a = 8'($urandom);
            cyc();
            check("rnd_idle_b", bus.b, model_b);
            check("rnd_idle_v", 8'(bus.b_valid), 8'(model_v));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin2gray_strobed.md
Name: bin2gray_strobed

Overview:
- Strobe-qualified binary-to-Gray encoder with a registered output.
- When `strobe` is high on a clock edge, the block captures the Gray code of input `a` into output `b`. Otherwise `b` holds its last value.
- Used as a leaf datapath element wherever a sampled binary bus must be published as reflected-binary Gray code.

Parameters:
- WIDTH, 8, bit width of the binary input `a` and the Gray output `b` (legal: WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  binary value to encode.
- strobe  input  1  capture enable; sampled on rising clk.
- b  output  WIDTH  registered Gray code of the last strobed `a`.
- b_valid  output  1  one-cycle pulse marking the cycle in which `b` has just been updated.

Behaviour:
- Encoding rule, combinational:
  - g[WIDTH-1] = a[WIDTH-1].
  - g[i] = a[i+1] XOR a[i] for i = WIDTH-2 down to 0.
  - Equivalently, g = a XOR (a >> 1), logical shift.
- Reset (rst_n low, asynchronous, immediate, no clock needed): b = 0, b_valid = 0. Both are held while rst_n is low.
- Reset release: the first rising clk with rst_n high resumes normal operation. No synchronous deassertion stage inside this block.
- On rising clk with rst_n high:
  - strobe = 1: b <= g(a), b_valid <= 1.
  - strobe = 0: b holds, b_valid <= 0.
- Latency: exactly 1 clock from the strobed edge to `b`.
- Strobe held high for N consecutive cycles: `b` tracks g(a) every cycle and `b_valid` stays high N cycles.
- `a` changing while strobe = 0 has no effect on `b`.
- Re-strobing the same `a` rewrites the same `b`; `b_valid` still pulses.
- Reset asserted mid-operation (between or during strobes): `b` clears to 0 immediately. The previously captured value is lost.
- No internal state other than the `b` and `b_valid` registers. No X propagation when inputs are known.

Decomposition:
- Shared package `gray_pkg`:
  - constant GRAY_WIDTH_DEFAULT = 8;
  - pure function `to_gray(bin)` returning bin XOR (bin >> 1), for reuse by other blocks and by the verification reference model.
- One natural sub-module: `gray_encode_comb`. It is the purely combinational WIDTH-parameterised encoder and is instantiated once, feeding the capture register.

Test Plan:
- Reset: drive rst_n = 0 with a = 0xFF, strobe = 1 -> b = 0x00 and b_valid = 0 immediately, with no clock required. Release rst_n and clock once with strobe = 1 -> b = 0x80.
- Directed encodings, WIDTH = 8, one strobe each; b must equal the listed value one cycle later with b_valid = 1:
  - 0x00 -> 0x00
  - 0x01 -> 0x01
  - 0x02 -> 0x03
  - 0x5A -> 0x77
  - 0x7F -> 0x40
  - 0x80 -> 0xC0
  - 0xFF -> 0x80
- Hold: strobe 0x5A (b = 0x77), then drive a = 0x00 for 10 cycles with strobe = 0 -> b stays 0x77 and b_valid = 0 throughout.
- Back-to-back: strobe high for 3 cycles with a = 0x03, 0x04, 0x05 -> b = 0x02, 0x06, 0x07 on successive cycles, b_valid high 3 cycles.
- Mid-operation reset: after b = 0xC0, pulse rst_n low between clock edges -> b = 0x00 at once. The next strobe with a = 0x80 restores b = 0xC0.
- Random regression: 20000 iterations, each with random a (bits biased ~40% ones), 1-cycle strobe, then idle cycles.
  - On every cycle, compare b against a reference model: register of to_gray(a) updated only on strobe, reset to 0.
  - Any mismatch fails the test.
